// File: rtl/mem_bank_arbiter.sv
// Shares NUM_BANKS low-order-interleaved SRAM banks between the CPU instruction-fetch
// and data ports; parallel service on distinct banks, starvation-bounded arbitration on conflict.
module mem_bank_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BANK_AW    = 14 - $clog2(NUM_BANKS),
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          im_req,
  input  logic [ADDR_W-1:0]             im_addr,
  output logic                          im_gnt,
  output logic                          im_rvalid,
  output logic [DATA_W-1:0]             im_rdata,
  input  logic                          dm_req,
  input  logic [3:0]                    dm_we,
  input  logic [ADDR_W-1:0]             dm_addr,
  input  logic [DATA_W-1:0]             dm_wdata,
  output logic                          dm_gnt,
  output logic                          dm_rvalid,
  output logic [DATA_W-1:0]             dm_rdata,
  output logic [NUM_BANKS-1:0]          bk_cs,
  output logic [NUM_BANKS-1:0]          bk_oe,
  output logic [4*NUM_BANKS-1:0]        bk_web,
  output logic [BANK_AW*NUM_BANKS-1:0]  bk_a,
  output logic [DATA_W*NUM_BANKS-1:0]   bk_di,
  input  logic [DATA_W*NUM_BANKS-1:0]   bk_do
);

  localparam int unsigned BSEL_W = $clog2(NUM_BANKS);
  localparam int unsigned BIDX_W = (BSEL_W == 0) ? 1 : BSEL_W;
  localparam int unsigned CNT_W  = 4;

  logic [BIDX_W-1:0]  w_im_bank;
  logic [BIDX_W-1:0]  w_dm_bank;
  logic [BANK_AW-1:0] w_im_row;
  logic [BANK_AW-1:0] w_dm_row;
  logic               w_conflict;
  logic               w_im_force;
  logic               w_im_gnt;
  logic               w_dm_gnt;
  logic               w_dm_rd;

  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_im_rv;
  logic               r_dm_rv;
  logic [BIDX_W-1:0]  r_im_bank;
  logic [BIDX_W-1:0]  r_dm_bank;

  // A single bank has no select bits; everything decodes to bank 0
  generate
    if (BSEL_W == 0) begin : g_one_bank
      assign w_im_bank = '0;
      assign w_dm_bank = '0;
    end else begin : g_multi_bank
      assign w_im_bank = im_addr[2 +: BSEL_W];
      assign w_dm_bank = dm_addr[2 +: BSEL_W];
    end
  endgenerate

  assign w_im_row = im_addr[2+BSEL_W +: BANK_AW];
  assign w_dm_row = dm_addr[2+BSEL_W +: BANK_AW];

  assign w_conflict = im_req && dm_req && (w_im_bank == w_dm_bank);
  assign w_im_force = (r_starve_cnt == CNT_W'(STARVE_MAX));
  assign w_im_gnt   = !rst && im_req && (!w_conflict || w_im_force);
  assign w_dm_gnt   = !rst && dm_req && (!w_conflict || !w_im_force);
  assign w_dm_rd    = (dm_we == 4'b0000);

  assign im_gnt = w_im_gnt;
  assign dm_gnt = w_dm_gnt;

  // Bank drive: at most one port owns any bank in a given cycle
  always_comb begin
    bk_cs  = '0;
    bk_oe  = '0;
    bk_web = '1;
    bk_a   = '0;
    bk_di  = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (w_im_gnt && (w_im_bank == BIDX_W'(b))) begin
        bk_cs[b]                   = 1'b1;
        bk_oe[b]                   = 1'b1;
        bk_a[b*BANK_AW +: BANK_AW] = w_im_row;
      end
      if (w_dm_gnt && (w_dm_bank == BIDX_W'(b))) begin
        bk_cs[b]                   = 1'b1;
        bk_oe[b]                   = w_dm_rd;
        bk_web[b*4 +: 4]           = ~dm_we;
        bk_a[b*BANK_AW +: BANK_AW] = w_dm_row;
        if (!w_dm_rd) begin
          bk_di[b*DATA_W +: DATA_W] = dm_wdata;
        end
      end
    end
  end

  // Starvation counter and read-return pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_im_rv      <= 1'b0;
      r_dm_rv      <= 1'b0;
      r_im_bank    <= '0;
      r_dm_bank    <= '0;
    end else begin
      if (w_im_gnt) begin
        r_starve_cnt <= '0;
      end else if (im_req && !w_im_force) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
      r_im_rv <= w_im_gnt;
      r_dm_rv <= w_dm_gnt && w_dm_rd;
      if (w_im_gnt) begin
        r_im_bank <= w_im_bank;
      end
      if (w_dm_gnt && w_dm_rd) begin
        r_dm_bank <= w_dm_bank;
      end
    end
  end

  // A response still in flight when reset arrives is suppressed
  assign im_rvalid = r_im_rv && !rst;
  assign dm_rvalid = r_dm_rv && !rst;
  assign im_rdata  = im_rvalid ? bk_do[DATA_W*32'(r_im_bank) +: DATA_W] : '0;
  assign dm_rdata  = dm_rvalid ? bk_do[DATA_W*32'(r_dm_bank) +: DATA_W] : '0;

endmodule
